// File: rtl/task_bus_pkg.sv
// Shared definitions for the task op bus: opcodes, op word layout, dispatcher FSM states.
package task_bus_pkg;

    typedef enum logic [3:0] {
        OP_NONE      = 4'h0,
        OP_READY     = 4'h1,
        OP_SUSPEND   = 4'h2,
        OP_WAIT      = 4'h3,
        OP_KILL      = 4'h4,
        OP_SETPRIO   = 4'h5,
        OP_SETEXEHIT = 4'h6,
        OP_EXECUTE   = 4'h7,
        OP_FINISH    = 4'hF
    } op_code_e;

    localparam int OP_ID_LSB   = 8;
    localparam int OP_CODE_LSB = 4;
    localparam int OP_ARG_LSB  = 0;

    localparam logic [15:0] OP_NOP = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST,
        ST_SCAN,
        ST_EXEC,
        ST_RUN,
        ST_FIN
    } state_e;

    function automatic logic [15:0] make_op(input logic [3:0] id, input op_code_e code);
        logic [15:0] op;
        op = OP_NOP;
        op[OP_ID_LSB   +: 4] = id;
        op[OP_CODE_LSB +: 4] = code;
        op[OP_ARG_LSB  +: 4] = 4'h0;
        return op;
    endfunction

endpackage

// File: rtl/task_dispatcher_if.sv
// Host queue handshake, task report words and the outgoing op bus of the dispatcher.
interface task_dispatcher_if #(parameter int N_TASKS = 8);

    logic                   host_valid;
    logic [15:0]            host_op;
    logic                   host_ready;
    logic [8*N_TASKS-1:0]   sorter_in;
    logic [15:0]            out_op;
    logic                   busy;
    logic [3:0]             cur_task;

    modport master (
        input  host_valid, host_op, sorter_in,
        output host_ready, out_op, busy, cur_task
    );

    modport slave (
        output host_valid, host_op, sorter_in,
        input  host_ready, out_op, busy, cur_task
    );

endinterface

// File: rtl/op_fifo.sv
// Synchronous FIFO holding host ops until the dispatcher is between slices.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop_ok ? AW'(1) : AW'(0));
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
        if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/task_dispatcher.sv
// Picks the highest-priority ready task, drives Execute / quantum / Finish slices on the op bus
// and issues queued host ops between slices.
module task_dispatcher
    import task_bus_pkg::*;
#(
    parameter int N_TASKS    = 8,
    parameter int QUANTUM    = 10000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    task_dispatcher_if.master bus
);

    localparam int CW = $clog2(QUANTUM) + 1;
    localparam int IW = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;

    state_e        state_q, state_d;
    logic [15:0]   out_op_q, out_op_d;
    logic          busy_q, busy_d;
    logic [3:0]    cur_task_q, cur_task_d;
    logic [IW-1:0] cur_idx_q, cur_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          any_ready;
    logic [IW-1:0] best_idx;
    logic [3:0]    best_prio;
    logic [7:0]    cur_word;
    logic [3:0]    cur_id;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [15:0]   fifo_head;

    op_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.host_valid),
        .push_data (bus.host_op),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        any_ready = 1'b0;
        best_idx  = '0;
        best_prio = '0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (bus.sorter_in[8*i +: 8] != 8'h00 &&
                (!any_ready || bus.sorter_in[8*i +: 4] > best_prio)) begin
                any_ready = 1'b1;
                best_idx  = IW'(i);
                best_prio = bus.sorter_in[8*i +: 4];
            end
        end
    end

    assign cur_word = bus.sorter_in[8*int'(cur_idx_q) +: 8];
    assign cur_id   = 4'(int'(cur_idx_q) + 1);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        out_op_d   = OP_NOP;
        busy_d     = busy_q;
        cur_task_d = cur_task_q;
        cur_idx_d  = cur_idx_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                cur_task_d = 4'h0;
                if (!fifo_empty)    state_d = ST_HOST;
                else if (any_ready) state_d = ST_SCAN;
            end
            ST_HOST: begin
                fifo_pop = 1'b1;
                out_op_d = fifo_head;
                state_d  = ST_IDLE;
            end
            ST_SCAN: begin
                cur_idx_d = best_idx;
                state_d   = any_ready ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                out_op_d   = make_op(cur_id, OP_EXECUTE);
                cur_task_d = cur_id;
                busy_d     = 1'b1;
                cnt_d      = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                // A task that leaves Ready forfeits its slice without a Finish op.
                if (cur_word == 8'h00) begin
                    busy_d     = 1'b0;
                    cur_task_d = 4'h0;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CW'(QUANTUM - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                out_op_d = make_op(cur_task_q, OP_FINISH);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_op_q   <= OP_NOP;
            busy_q     <= 1'b0;
            cur_task_q <= 4'h0;
            cur_idx_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_op_q   <= out_op_d;
            busy_q     <= busy_d;
            cur_task_q <= cur_task_d;
            cur_idx_q  <= cur_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.host_ready = !fifo_full;
    assign bus.out_op     = out_op_q;
    assign bus.busy       = busy_q;
    assign bus.cur_task   = cur_task_q;

endmodule
